// File: rtl/packet_arb_pkg.sv
// rtl/packet_arb_pkg.sv - shared types and round-robin helpers for packet_rr_arbiter
package packet_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping explicitly at num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int                   num_req);
    rr_pick_t r;
    int       i;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      i = int'(ptr) + k;
      if (i >= num_req) i = i - num_req;
      if (k < num_req && !r.found && valid[i[MAX_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = i[MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_IDX_W-1:0] idx,
                                                   input int                   num_req);
    return (int'(idx) >= num_req - 1) ? '0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/packet_rr_arbiter_if.sv
// rtl/packet_rr_arbiter_if.sv - upstream request and downstream beat channel bundle
interface packet_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [SRC_W-1:0]          out_src;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );

  // Requesters plus downstream sink side
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );

endinterface

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick: valid + pointer -> onehot + index
module rr_priority_select
  import packet_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [SRC_W-1:0]   idx_o
);

  logic [MAX_REQ-1:0]   valid_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;
  rr_pick_t             pick;

  always_comb begin
    valid_ext                 = '0;
    valid_ext[NUM_REQ-1:0]    = valid_i;
    ptr_ext                   = '0;
    ptr_ext[SRC_W-1:0]        = ptr_i;
    pick                      = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    found_o                   = pick.found;
    idx_o                     = pick.idx[SRC_W-1:0];
    onehot_o                  = '0;
    onehot_o[idx_o]           = pick.found;
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// rtl/packet_rr_arbiter.sv - packet-aware round-robin arbiter with registered output; PACKET_RR_ARB_WDOG_EN adds a mid-packet stall watchdog
module packet_rr_arbiter
  import packet_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32
`ifdef PACKET_RR_ARB_WDOG_EN
  , parameter int WDOG_CYCLES = 255
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  packet_rr_arbiter_if.slave  bus,
  output logic                busy
`ifdef PACKET_RR_ARB_WDOG_EN
  , output logic              wdog_err
`endif
);

  localparam int SRC_W = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     grant_q, grant_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;

  logic                 stage_en;
  logic                 sel_found;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [SRC_W-1:0]     sel_idx;
  logic [SRC_W-1:0]     own_idx;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 accept;
  logic                 acc_last;
  logic [DATA_W-1:0]    acc_data;
  logic [MAX_IDX_W-1:0] own_next;
  logic                 wdog_fire;

  rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .valid_i  (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .found_o  (sel_found),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx)
  );

  // Grant and handshake; held low throughout reset so no beat is lost.
  always_comb begin
    stage_en  = !out_valid_q || bus.out_ready;
    own_idx   = (state_q == IDLE) ? sel_idx : grant_q;
    req_ready = '0;
    if (reset_n) begin
      if (state_q == IDLE) begin
        if (sel_found && stage_en) req_ready = sel_onehot;
      end else begin
        req_ready[grant_q] = stage_en;
      end
    end
    accept   = |(bus.req_valid & req_ready);
    acc_last = bus.req_last[own_idx];
    acc_data = bus.req_data[int'(own_idx)*DATA_W +: DATA_W];
    own_next = rr_next(MAX_IDX_W'(own_idx), NUM_REQ);
  end

`ifdef PACKET_RR_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] stall_q, stall_d;
  logic              wdog_err_q;

  always_comb begin
    stall_d   = stall_q;
    wdog_fire = 1'b0;
    if (state_q == IDLE || accept) begin
      stall_d = '0;
    end else if (!bus.req_valid[grant_q]) begin
      if (stall_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_fire = 1'b1;
        stall_d   = '0;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q    <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      wdog_err_q <= wdog_fire;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_fire = 1'b0;
`endif

  // Pointer moves only on packet completion (or watchdog abort), never per beat.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_last) begin
            rr_ptr_d = own_next[SRC_W-1:0];
          end else begin
            state_d = LOCKED;
            grant_d = own_idx;
          end
        end
      end
      LOCKED: begin
        if ((accept && acc_last) || wdog_fire) begin
          state_d  = IDLE;
          rr_ptr_d = own_next[SRC_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (stage_en) begin
      out_valid_d = accept;
      if (accept) begin
        out_last_d = acc_last;
        out_data_d = acc_data;
        out_src_d  = own_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign busy          = (state_q == LOCKED);

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready wide-word channel between NUM_REQ upstream requesters.
- Typical sink: a bus width decrease serializer.
- Packet-aware: the grant is held from the first beat until the beat with last=1 is accepted, so packets from different requesters never interleave.
- The output passes through one registered pipeline stage that carries the source ID alongside each beat.

Parameters:
- NUM_REQ, 4, number of requesters; 2 to 16.
- DATA_W, 32, beat width in bits.
- SRC_W, $clog2(NUM_REQ), width of the source ID (localparam, derived).
- WDOG_CYCLES, 255, mid-packet stall limit. Used only with the optional feature.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_ready  output  NUM_REQ  per-requester beat accept; at most one bit high.
- req_data  input  NUM_REQ*DATA_W  packed beats; requester i occupies [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  per-requester end-of-packet marker.
- out_valid  output  1  registered beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  registered beat.
- out_last  output  1  registered end-of-packet marker.
- out_src  output  SRC_W  index of the requester that owns the beat.
- busy  output  1  high while state is LOCKED.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_src=0.
  - req_ready=0 while reset_n is low; busy=0.
- Pipeline-stage enable: stage_en = !out_valid || out_ready. Full throughput; no bubble between beats or between packets.
- IDLE:
  - Combinationally pick sel = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - If any requester is valid and stage_en=1: req_ready[sel]=1 and the beat transfers this cycle.
  - If the beat has req_last=1: stay IDLE and set rr_ptr = (sel+1) mod NUM_REQ.
  - Otherwise: go to LOCKED and latch grant=sel.
- LOCKED:
  - req_ready[grant] = stage_en; every other req_ready bit is 0.
  - When a beat is accepted with req_last[grant]=1: go to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
  - Requester valid dropping mid-packet is legal; the grant is held regardless.
- Transfer on cycle t (req_valid & req_ready) loads out_data/out_last/out_src at edge t+1. Latency is 1 cycle.
- When stage_en=1 and no beat is accepted, out_valid clears at the next edge.
- out_* is held stable while out_valid=1 and out_ready=0.
- rr_ptr advances only on packet completion, never on an individual beat.
- Boundary cases:
  - No requester valid in IDLE: no grant, pointer unchanged.
  - NUM_REQ not a power of two: wrap explicitly from NUM_REQ-1 to 0.
  - A requester that becomes valid in the same cycle another packet completes waits for the next IDLE cycle. IDLE re-arbitrates in the same cycle the state is entered.
  - Single-beat packets from all requesters: strict rotation 0,1,2,3,0,...
- Upstream rule: req_data and req_last stay stable while req_valid=1 and req_ready=0. The bench asserts this; the RTL does not check it.

Optional Feature:
- Macro: PACKET_RR_ARB_WDOG_EN.
- Defined:
  - A stall counter resets to 0 on every accepted beat and in IDLE.
  - In LOCKED, it increments each cycle that req_valid[grant]=0.
  - At WDOG_CYCLES it forces state to IDLE, advances rr_ptr past grant, and pulses output wdog_err high for one cycle.
  - The downstream packet is left truncated; no last beat is emitted.
  - Adds port wdog_err, output, 1 bit, reset 0.
- Undefined: no counter and no wdog_err port; the grant is held indefinitely.

Decomposition:
- Package packet_arb_pkg holds:
  - typedef enum {IDLE, LOCKED} arb_state_t.
  - Function rr_pick(valid, ptr) returning found and index.
- One natural sub-module: rr_priority_select. It is combinational, parameterized by NUM_REQ, and maps valid + ptr to onehot grant + index.
- The pipeline stage stays inline.

Test Plan:
- Reset with req_valid=4'b1111 held → req_ready=0 and out_valid=0 during reset. After release, first grant goes to 0, and out_src sequence is 0,1,2,3,0 with single-beat packets and out_ready=1.
- Requester 1 sends a 3-beat packet (A,B,C, last on C) while requester 2 is valid throughout → out_data A,B,C all with out_src=1 on consecutive cycles; requester 2's first beat follows immediately after C with no gap.
- out_ready low for 5 cycles mid-packet → out_data/out_last/out_src frozen; req_ready[grant]=0; no beat lost or duplicated.
- Requester 3 drops valid for 4 cycles mid-packet while requester 0 is valid → no grant to 0 until requester 3 sends its last beat; rr_ptr then becomes 0.
- Assert reset_n low while LOCKED with out_valid=1 → out_valid=0 and busy=0 immediately, without waiting for a clock edge; after release arbitration restarts from requester 0.
- With PACKET_RR_ARB_WDOG_EN and WDOG_CYCLES=8: requester 2 stalls mid-packet for 8 cycles → wdog_err pulses once, busy falls, and requester 3 is granted next.
